demux_stream1to4: RTL

//  Registered 1-to-4 stream demultiplexer: the write-side counterpart to the 4:1 select muxes.

---
 rtl/demux_stream1to4_pkg.sv | 17 +
 rtl/demux_slot.sv | 42 ++++
 rtl/demux_stream1to4.sv | 79 +++++++
 3 files changed

// File: rtl/demux_stream1to4_pkg.sv
// Shared sizing constants and address decode for the 1-to-4 stream demultiplexer.
package demux_stream1to4_pkg;

    localparam int unsigned DEMUX_NOUT   = 4;
    localparam int unsigned DEMUX_ADDR_W = 2;
    localparam int unsigned DEMUX_STAT_W = 16;

    typedef logic [DEMUX_NOUT-1:0] chan_mask_t;

    function automatic chan_mask_t addr_decode(input logic [DEMUX_ADDR_W-1:0] addr);
        chan_mask_t mask;
        mask       = '0;
        mask[addr] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry holding register for a single demux output channel.
module demux_slot #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             drain,
    input  logic [WIDTH-1:0] din,
    output logic             valid,
    output logic [WIDTH-1:0] dout
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;

    // A load wins over a same-cycle drain so the slot refills without a bubble.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = din;
        end else if (drain) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign dout  = data_q;

endmodule

// File: rtl/demux_stream1to4.sv
// Registered 1-to-4 valid/ready stream demultiplexer, one holding slot per channel.
// Define DEMUX_STATS_EN to add saturating per-channel drain counters stat_cnt0..stat_cnt3.
module demux_stream1to4
    import demux_stream1to4_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DEMUX_ADDR_W-1:0] in_addr,
    input  logic [WIDTH-1:0]        in_data,
    output logic [DEMUX_NOUT-1:0]   out_valid,
    input  logic [DEMUX_NOUT-1:0]   out_ready,
    output logic [WIDTH-1:0]        out_data0,
    output logic [WIDTH-1:0]        out_data1,
    output logic [WIDTH-1:0]        out_data2,
`ifdef DEMUX_STATS_EN
    output logic [DEMUX_STAT_W-1:0] stat_cnt0,
    output logic [DEMUX_STAT_W-1:0] stat_cnt1,
    output logic [DEMUX_STAT_W-1:0] stat_cnt2,
    output logic [DEMUX_STAT_W-1:0] stat_cnt3,
`endif
    output logic [WIDTH-1:0]        out_data3
);

    chan_mask_t       sel;
    chan_mask_t       load;
    chan_mask_t       drain;
    logic [WIDTH-1:0] slot_data [DEMUX_NOUT];

    assign sel      = addr_decode(in_addr);
    // A full slot that drains this cycle still accepts, keeping 1 word/cycle per channel.
    assign in_ready = ~out_valid[in_addr] | out_ready[in_addr];
    assign load     = sel & {DEMUX_NOUT{in_valid & in_ready}};
    assign drain    = out_valid & out_ready;

    for (genvar k = 0; k < DEMUX_NOUT; k++) begin : g_slot
        demux_slot #(
            .WIDTH(WIDTH)
        ) u_slot (
            .clk    (clk),
            .reset_n(reset_n),
            .load   (load[k]),
            .drain  (drain[k]),
            .din    (in_data),
            .valid  (out_valid[k]),
            .dout   (slot_data[k])
        );
    end

    assign out_data0 = slot_data[0];
    assign out_data1 = slot_data[1];
    assign out_data2 = slot_data[2];
    assign out_data3 = slot_data[3];

`ifdef DEMUX_STATS_EN
    logic [DEMUX_STAT_W-1:0] stat_q [DEMUX_NOUT];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < DEMUX_NOUT; k++) stat_q[k] <= '0;
        end else begin
            for (int k = 0; k < DEMUX_NOUT; k++) begin
                if (drain[k] && (stat_q[k] != '1)) stat_q[k] <= stat_q[k] + 1'b1;
            end
        end
    end

    assign stat_cnt0 = stat_q[0];
    assign stat_cnt1 = stat_q[1];
    assign stat_cnt2 = stat_q[2];
    assign stat_cnt3 = stat_q[3];
`else
    // Statistics disabled: drains only clear their slots.
`endif

endmodule
